mem_burst: RTL

//  Parametrised single-port word memory with a valid/ready command handshake and incrementing bursts.

---
 rtl/mem_burst.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_burst.sv
// mem_burst: single-port word RAM with a valid/ready command handshake, incrementing bursts
// and a post-reset zero sweep. Optional per-byte even parity when MEM_PARITY_EN is defined.
module mem_burst #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = $clog2(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rlast,
  output logic                  busy
`ifdef MEM_PARITY_EN
  ,
  input  logic                  par_inj,
  output logic                  perr
`endif
);

  localparam int NB = WIDTH / 8;
  localparam int unsigned LAST_I  = DEPTH - 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = LAST_I[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = DEPTH_U[ADDR_WIDTH:0];

  typedef enum logic [2:0] {CLEAR, IDLE, WR, RD, RD_END} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0]   clr_ptr_reg, clr_ptr_next;
  logic [LEN_WIDTH-1:0]    cnt_reg, cnt_next;
  logic                    rvalid_reg, rvalid_next;
  logic                    rlast_reg, rlast_next;
  logic                    fetch;
  logic                    wr_beat;
  logic                    clearing;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [ADDR_WIDTH-1:0]   addr_mod;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  // Only reachable for non-power-of-2 DEPTH; one subtraction suffices since addr < 2*DEPTH.
  always_comb begin
    addr_mod = addr;
    if ({1'b0, addr} >= DEPTH_EXT)
      addr_mod = addr - DEPTH_EXT[ADDR_WIDTH-1:0];
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    clr_ptr_next = clr_ptr_reg;
    rvalid_next  = rvalid_reg;
    rlast_next   = rlast_reg;
    fetch        = 1'b0;
    wr_beat      = 1'b0;
    case (state_reg)
      CLEAR: begin
        clr_ptr_next = clr_ptr_reg + 1'b1;
        if (clr_ptr_reg == LAST_ADDR) begin
          clr_ptr_next = '0;
          state_next   = IDLE;
        end
      end
      IDLE: begin
        if (valid) begin
          ptr_next   = addr_mod;
          cnt_next   = len;
          state_next = wr_rd ? WR : RD;
        end
      end
      WR: begin
        if (wvalid) begin
          wr_beat = 1'b1;
          if (cnt_reg == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
            ptr_next = ptr_inc(ptr_reg);
          end
        end
      end
      RD: begin
        // Output slot is free or being drained this cycle: pull the next word.
        if (!rvalid_reg || rready) begin
          fetch       = 1'b1;
          rvalid_next = 1'b1;
          rlast_next  = (cnt_reg == '0);
          ptr_next    = ptr_inc(ptr_reg);
          cnt_next    = cnt_reg - 1'b1;
          if (cnt_reg == '0)
            state_next = RD_END;
        end
      end
      RD_END: begin
        if (rready) begin
          rvalid_next = 1'b0;
          rlast_next  = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      rvalid_reg  <= rvalid_next;
      rlast_reg   <= rlast_next;
    end
  end

  assign clearing = (state_reg == CLEAR);
  assign wr_addr  = clearing ? clr_ptr_reg : ptr_reg;

  assign ready  = (state_reg == IDLE);
  assign wready = (state_reg == WR);
  assign busy   = (state_reg != IDLE);
  assign rvalid = rvalid_reg;
  assign rlast  = rlast_reg;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] lane_perr;
`endif

  // One RAM per byte lane so strobes map onto independent write enables.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rbyte_reg;
      logic       we;
      logic [7:0] wbyte;

      assign we    = !res && (clearing || (wr_beat && wstrb[gi]));
      assign wbyte = clearing ? 8'h00 : wdata[8*gi +: 8];

      always_ff @(posedge clk) begin
        if (we)
          mem_lane[wr_addr] <= wbyte;
      end

      always_ff @(posedge clk) begin
        if (res)
          rbyte_reg <= 8'h00;
        else if (fetch)
          rbyte_reg <= mem_lane[ptr_reg];
      end

      assign rdata[8*gi +: 8] = rbyte_reg;

`ifdef MEM_PARITY_EN
      logic par_lane [DEPTH];
      logic rpar_reg;

      always_ff @(posedge clk) begin
        if (we)
          par_lane[wr_addr] <= clearing ? 1'b0 : ((^wbyte) ^ par_inj);
      end

      always_ff @(posedge clk) begin
        if (res)
          rpar_reg <= 1'b0;
        else if (fetch)
          rpar_reg <= par_lane[ptr_reg];
      end

      assign lane_perr[gi] = (^rbyte_reg) ^ rpar_reg;
`endif
    end
  endgenerate

`ifdef MEM_PARITY_EN
  assign perr = rvalid_reg && (|lane_perr);
`endif

endmodule
